uart_frame_tx: RTL and testbench

- Transmit half of the Herculus UART link.
- Accepts a byte over a valid/ready handshake and builds the 11-bit frame: start 0, data[7:0] LSB first, parity, stop 1.
- Shifts the frame onto a single serial line at a fixed number of clocks per bit.
- Frame format matches the receive-side DeFrame path, so a loopback of tx_serial through the receiver reproduces the byte.

---
 rtl/uart_frame_tx.sv | 124 ++++++++++++
 tb/tb_uart_frame_tx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: UART transmit framer, byte in over valid/ready, frame out LSB first.
// Define UART_TX_PARITY_EN to include the parity bit; otherwise the frame is start/data/stop only.
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_serial,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [10:0] frame_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic             line_nxt;
  logic             accept;
  logic             bit_end;
  logic             par_sel;

  function automatic logic par_bit(input logic [7:0] d);
    return PARITY_ODD ? ~^d : ^d;
  endfunction

  assign accept  = tx_valid && tx_ready;
  assign bit_end = (cnt == CNT_LAST);

`ifdef UART_TX_PARITY_EN
  assign par_sel = par_bit(tx_data);
`else
  assign par_sel = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_START;
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA: begin
        if (bit_end && idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP:   if (bit_end) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Line value is chosen from the next state so the registered output lands on bit boundaries.
  always_comb begin
    tx_ready = (state == S_IDLE);
    tx_busy  = (state != S_IDLE);
    line_nxt = 1'b1;
    case (state_nxt)
      S_IDLE:   line_nxt = 1'b1;
      S_START:  line_nxt = 1'b0;
      S_DATA:   line_nxt = shift_nxt[0];
      S_PARITY: line_nxt = frame_out[9];
      S_STOP:   line_nxt = 1'b1;
      default:  line_nxt = 1'b1;
    endcase
  end

  always_comb begin
    shift_nxt = shift;
    if (accept)                        shift_nxt = tx_data;
    else if (state == S_DATA && bit_end) shift_nxt = {1'b0, shift[7:1]};
  end

  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= 3'd0;
      tx_serial <= 1'b1;
      tx_done   <= 1'b0;
      frame_out <= 11'h7FF;
    end else begin
      if (state == S_IDLE || bit_end) cnt <= '0;
      else                            cnt <= cnt + 1'b1;

      if (state != S_DATA)  idx <= 3'd0;
      else if (bit_end)     idx <= idx + 3'd1;

      tx_serial <= line_nxt;
      tx_done   <= (state == S_STOP) && bit_end;

      if (accept) frame_out <= {1'b1, par_sel, tx_data, 1'b0};
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx at 4 clocks per bit; even- and odd-parity instances.
module tb_uart_frame_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int NBITS  = 10 + PAR_EN;
  localparam int DONE_C = NBITS * CPB + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_e, data_o;
  logic        valid_e, valid_o;
  logic        ready_e, serial_e, busy_e, done_e;
  logic        ready_o, serial_o, busy_o, done_o;
  logic [10:0] frame_e, frame_o;
  logic [10:0] exp_frame;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  uart_frame_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_data(data_e), .tx_valid(valid_e),
    .tx_ready(ready_e), .tx_serial(serial_e), .tx_busy(busy_e),
    .tx_done(done_e), .frame_out(frame_e)
  );

  uart_frame_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(data_o), .tx_valid(valid_o),
    .tx_ready(ready_o), .tx_serial(serial_o), .tx_busy(busy_o),
    .tx_done(done_o), .frame_out(frame_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k, input bit odd);
    logic [7:0] t;
    if (k == 0) return 1'b0;
    if (k <= 8) begin
      t = d >> (k - 1);
      return t[0];
    end
    if (PAR_EN == 1 && k == 9) return odd ? ~^d : ^d;
    return 1'b1;
  endfunction

  task automatic send(input logic [7:0] d, input bit odd, input bit hold,
                      input logic [7:0] d_next, input int glitch_c, input int abort_c);
    logic obs_ser, obs_rdy, obs_done, obs_busy, exp_ser;
    if (odd) begin data_o = d; valid_o = 1'b1; end
    else     begin data_e = d; valid_e = 1'b1; end
    @(posedge clk);
    #1;
    if (hold) begin
      if (odd) data_o = d_next; else data_e = d_next;
    end else begin
      if (odd) valid_o = 1'b0; else valid_e = 1'b0;
    end
    for (int c = 1; c <= DONE_C; c++) begin
      @(negedge clk);
      obs_ser  = odd ? serial_o : serial_e;
      obs_rdy  = odd ? ready_o  : ready_e;
      obs_done = odd ? done_o   : done_e;
      obs_busy = odd ? busy_o   : busy_e;
      exp_ser  = (c <= NBITS * CPB) ? exp_bit(d, (c - 1) / CPB, odd) : 1'b1;
      check($sformatf("serial d=%0h c=%0d", d, c), 32'(obs_ser), 32'(exp_ser));
      check($sformatf("ready d=%0h c=%0d", d, c), 32'(obs_rdy), 32'(c == DONE_C));
      check($sformatf("done d=%0h c=%0d", d, c), 32'(obs_done), 32'(c == DONE_C));
      check($sformatf("busy d=%0h c=%0d", d, c), 32'(obs_busy), 32'(c != DONE_C));
      if (c == glitch_c) begin data_e = 8'h99; valid_e = 1'b1; end
      if (c == glitch_c + 1) valid_e = 1'b0;
      if (c == abort_c) begin
        rst_n = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    valid_e = 1'b1;
    valid_o = 1'b1;
    data_e  = 8'h55;
    data_o  = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst serial", 32'(serial_e), 32'(1'b1));
    check("rst ready", 32'(ready_e), 32'(1'b1));
    check("rst busy", 32'(busy_e), 32'(1'b0));
    check("rst done", 32'(done_e), 32'(1'b0));
    check("rst frame", 32'(frame_e), 32'(11'h7FF));
    check("rst frame odd", 32'(frame_o), 32'(11'h7FF));
    valid_e = 1'b0;
    valid_o = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    check("post-rst ready", 32'(ready_e), 32'(1'b1));
    check("post-rst serial", 32'(serial_e), 32'(1'b1));

    send(8'hA5, 1'b0, 1'b0, 8'h00, -1, -1);
    exp_frame = (PAR_EN == 1) ? 11'b1_0_10100101_0 : 11'b1_1_10100101_0;
    check("frame A5", 32'(frame_e), 32'(exp_frame));

    send(8'h01, 1'b1, 1'b0, 8'h00, -1, -1);
    exp_frame = (PAR_EN == 1) ? 11'b1_0_00000001_0 : 11'b1_1_00000001_0;
    check("frame 01 odd", 32'(frame_o), 32'(exp_frame));

    send(8'h00, 1'b0, 1'b1, 8'hFF, -1, -1);
    send(8'hFF, 1'b0, 1'b0, 8'h00, -1, -1);
    exp_frame = (PAR_EN == 1) ? 11'b1_0_11111111_0 : 11'b1_1_11111111_0;
    check("frame FF", 32'(frame_e), 32'(exp_frame));

    send(8'h3C, 1'b0, 1'b0, 8'h00, 10, -1);
    exp_frame = (PAR_EN == 1) ? 11'b1_0_00111100_0 : 11'b1_1_00111100_0;
    check("frame 3C", 32'(frame_e), 32'(exp_frame));

    send(8'hC3, 1'b0, 1'b0, 8'h00, -1, 20);
    @(negedge clk);
    check("abort serial", 32'(serial_e), 32'(1'b1));
    check("abort ready", 32'(ready_e), 32'(1'b1));
    check("abort busy", 32'(busy_e), 32'(1'b0));
    check("abort done", 32'(done_e), 32'(1'b0));
    check("abort frame", 32'(frame_e), 32'(11'h7FF));
    repeat (2) begin
      @(negedge clk);
      check("abort no done", 32'(done_e), 32'(1'b0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("release no done", 32'(done_e), 32'(1'b0));
    send(8'h5A, 1'b0, 1'b0, 8'h00, -1, -1);
    exp_frame = (PAR_EN == 1) ? 11'b1_0_01011010_0 : 11'b1_1_01011010_0;
    check("frame 5A", 32'(frame_e), 32'(exp_frame));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
